// File: rtl/register_file_sb_pkg.sv
// Shared register-file constants used by the register file, decode and control unit.
package register_file_sb_pkg;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned ZERO_IDX   = 0;
endpackage

// File: rtl/register_file_sb_scoreboard.sv
// Per-register busy scoreboard: reservation, WAW stall, write-back clear, flush and pending count.
module reg_scoreboard
  import register_file_sb_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic              busy_a,
  output logic              busy_b,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_addr,
  output logic              issue_stall,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic              flush,
  output logic [ADDR_W:0]   pending_count
);
  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [ADDR_W:0]  pending_count_q, pending_count_d;
  logic             issue_is_zero;

  assign busy_a        = busy_q[rd_addr_a];
  assign busy_b        = busy_q[rd_addr_b];
  assign issue_is_zero = (ZERO_REG != 0) && (issue_addr == ADDR_W'(ZERO_IDX));
  assign issue_stall   = issue_valid & busy_q[issue_addr]
                       & ~(wb_valid & (wb_addr == issue_addr));
  assign pending_count = pending_count_q;

  always_comb begin
    busy_d = busy_q;
    if (wb_valid) busy_d[wb_addr] = 1'b0;
    // Set after the clear so a same-cycle reissue of the written register stays busy.
    if (issue_valid && !issue_stall && !issue_is_zero) busy_d[issue_addr] = 1'b1;
    if (flush) busy_d = '0;

    pending_count_d = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      pending_count_d = pending_count_d + {{ADDR_W{1'b0}}, busy_d[i]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q          <= '0;
      pending_count_q <= '0;
    end else begin
      busy_q          <= busy_d;
      pending_count_q <= pending_count_d;
    end
  end
endmodule

// File: rtl/register_file_sb.sv
// DEPTH x DATA_W register file: two combinational read ports with write bypass,
// optional hard-wired zero register, and a busy scoreboard for hazard detection.
module register_file_sb
  import register_file_sb_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_busy_a,
  output logic              rd_busy_b,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_addr,
  output logic              issue_stall,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic [ADDR_W:0]   pending_count
);
  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_IDX);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic              sb_busy_a, sb_busy_b;
  logic              wb_is_zero;

  reg_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk           (clk),
    .rst_n         (reset),
    .rd_addr_a     (rd_addr_a),
    .rd_addr_b     (rd_addr_b),
    .busy_a        (sb_busy_a),
    .busy_b        (sb_busy_b),
    .issue_valid   (issue_valid),
    .issue_addr    (issue_addr),
    .issue_stall   (issue_stall),
    .wb_valid      (wb_valid),
    .wb_addr       (wb_addr),
    .flush         (flush),
    .pending_count (pending_count)
  );

  assign wb_is_zero = (ZERO_REG != 0) && (wb_addr == ZERO_ADDR);

  always_comb begin
    regs_d = regs_q;
    if (wb_valid && !wb_is_zero) regs_d[wb_addr] = wb_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Zero-register check comes last so it overrides a bypass hit on address 0.
  always_comb begin
    rd_data_a = regs_q[rd_addr_a];
    rd_busy_a = sb_busy_a;
    if ((BYPASS != 0) && wb_valid && (wb_addr == rd_addr_a)) begin
      rd_data_a = wb_data;
      rd_busy_a = 1'b0;
    end
    if ((ZERO_REG != 0) && (rd_addr_a == ZERO_ADDR)) begin
      rd_data_a = '0;
      rd_busy_a = 1'b0;
    end
  end

  always_comb begin
    rd_data_b = regs_q[rd_addr_b];
    rd_busy_b = sb_busy_b;
    if ((BYPASS != 0) && wb_valid && (wb_addr == rd_addr_b)) begin
      rd_data_b = wb_data;
      rd_busy_b = 1'b0;
    end
    if ((ZERO_REG != 0) && (rd_addr_b == ZERO_ADDR)) begin
      rd_data_b = '0;
      rd_busy_b = 1'b0;
    end
  end
endmodule

// File: tb/tb_register_file_sb.sv
// Directed self-checking bench for register_file_sb with default parameters.
module tb_register_file_sb;
  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rd_addr_a, rd_addr_b, issue_addr, wb_addr;
  logic [31:0] rd_data_a, rd_data_b, wb_data;
  logic        rd_busy_a, rd_busy_b, issue_valid, issue_stall, wb_valid, flush;
  logic [5:0]  pending_count;

  int checks = 0;
  int errors = 0;

  register_file_sb #(
    .DATA_W   (32),
    .ADDR_W   (5),
    .ZERO_REG (1),
    .BYPASS   (1)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .rd_addr_a     (rd_addr_a),
    .rd_addr_b     (rd_addr_b),
    .rd_data_a     (rd_data_a),
    .rd_data_b     (rd_data_b),
    .rd_busy_a     (rd_busy_a),
    .rd_busy_b     (rd_busy_b),
    .issue_valid   (issue_valid),
    .issue_addr    (issue_addr),
    .issue_stall   (issue_stall),
    .wb_valid      (wb_valid),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data),
    .flush         (flush),
    .pending_count (pending_count)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    issue_valid = 1'b0;
    wb_valid    = 1'b0;
    flush       = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0; idle();
    rd_addr_a = 5'd1; rd_addr_b = 5'd31; issue_addr = 5'd0; wb_addr = 5'd0; wb_data = '0;
    #12;
    reset = 1'b1;
    tick();
    checks++;
    if (rd_data_a !== 32'h0) begin errors++; $display("FAIL reset_data_a: got %h expected %h", rd_data_a, 32'h0); end
    checks++;
    if (rd_data_b !== 32'h0) begin errors++; $display("FAIL reset_data_b: got %h expected %h", rd_data_b, 32'h0); end
    checks++;
    if ({rd_busy_a, rd_busy_b} !== 2'b00) begin errors++; $display("FAIL reset_busy: got %b expected %b", {rd_busy_a, rd_busy_b}, 2'b00); end
    checks++;
    if (pending_count !== 6'd0) begin errors++; $display("FAIL reset_count: got %0d expected %0d", pending_count, 0); end
    checks++;
    if (issue_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected %b", issue_stall, 1'b0); end
  endtask

  task automatic test_write_read;
    wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'hDEADBEEF;
    rd_addr_a = 5'd1; rd_addr_b = 5'd3;
    #1;
    checks++;
    if (rd_data_b !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_b: got %h expected %h", rd_data_b, 32'hDEADBEEF); end
    checks++;
    if (rd_data_a !== 32'h0) begin errors++; $display("FAIL unwritten_a: got %h expected %h", rd_data_a, 32'h0); end
    tick();
    wb_valid = 1'b0; rd_addr_a = 5'd3;
    #1;
    checks++;
    if (rd_data_a !== 32'hDEADBEEF) begin errors++; $display("FAIL stored_a: got %h expected %h", rd_data_a, 32'hDEADBEEF); end
  endtask

  task automatic test_zero_reg;
    wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'h12345678; rd_addr_a = 5'd0;
    #1;
    checks++;
    if (rd_data_a !== 32'h0) begin errors++; $display("FAIL zero_bypass: got %h expected %h", rd_data_a, 32'h0); end
    tick();
    wb_valid = 1'b0; issue_valid = 1'b1; issue_addr = 5'd0;
    tick();
    issue_valid = 1'b0;
    #1;
    checks++;
    if (rd_data_a !== 32'h0) begin errors++; $display("FAIL zero_data: got %h expected %h", rd_data_a, 32'h0); end
    checks++;
    if (rd_busy_a !== 1'b0) begin errors++; $display("FAIL zero_busy: got %b expected %b", rd_busy_a, 1'b0); end
    checks++;
    if (pending_count !== 6'd0) begin errors++; $display("FAIL zero_count: got %0d expected %0d", pending_count, 0); end
    issue_valid = 1'b1; issue_addr = 5'd0;
    #1;
    checks++;
    if (issue_stall !== 1'b0) begin errors++; $display("FAIL zero_stall: got %b expected %b", issue_stall, 1'b0); end
    issue_valid = 1'b0;
  endtask

  task automatic test_scoreboard;
    issue_valid = 1'b1; issue_addr = 5'd5;
    #1;
    checks++;
    if (issue_stall !== 1'b0) begin errors++; $display("FAIL sb_first_stall: got %b expected %b", issue_stall, 1'b0); end
    tick();
    issue_valid = 1'b0; rd_addr_a = 5'd5;
    #1;
    checks++;
    if (rd_busy_a !== 1'b1) begin errors++; $display("FAIL sb_busy_set: got %b expected %b", rd_busy_a, 1'b1); end
    checks++;
    if (pending_count !== 6'd1) begin errors++; $display("FAIL sb_count1: got %0d expected %0d", pending_count, 1); end
    issue_valid = 1'b1;
    #1;
    checks++;
    if (issue_stall !== 1'b1) begin errors++; $display("FAIL sb_waw_stall: got %b expected %b", issue_stall, 1'b1); end
    tick();
    issue_valid = 1'b0;
    #1;
    checks++;
    if (pending_count !== 6'd1 || rd_busy_a !== 1'b1) begin errors++; $display("FAIL sb_stall_hold: got count %0d busy %b expected count 1 busy 1", pending_count, rd_busy_a); end
    wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'h55;
    #1;
    checks++;
    if (rd_data_a !== 32'h55 || rd_busy_a !== 1'b0) begin errors++; $display("FAIL sb_wb_bypass: got %h/%b expected 00000055/0", rd_data_a, rd_busy_a); end
    tick();
    wb_valid = 1'b0;
    #1;
    checks++;
    if (rd_busy_a !== 1'b0) begin errors++; $display("FAIL sb_busy_clear: got %b expected %b", rd_busy_a, 1'b0); end
    checks++;
    if (pending_count !== 6'd0) begin errors++; $display("FAIL sb_count0: got %0d expected %0d", pending_count, 0); end
    checks++;
    if (rd_data_a !== 32'h55) begin errors++; $display("FAIL sb_data: got %h expected %h", rd_data_a, 32'h55); end
  endtask

  task automatic test_simultaneous;
    issue_valid = 1'b1; issue_addr = 5'd7;
    tick();
    wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 32'h77;
    #1;
    checks++;
    if (issue_stall !== 1'b0) begin errors++; $display("FAIL sim_stall: got %b expected %b", issue_stall, 1'b0); end
    tick();
    idle(); rd_addr_a = 5'd7;
    #1;
    checks++;
    if (rd_data_a !== 32'h77) begin errors++; $display("FAIL sim_data: got %h expected %h", rd_data_a, 32'h77); end
    checks++;
    if (rd_busy_a !== 1'b1) begin errors++; $display("FAIL sim_busy: got %b expected %b", rd_busy_a, 1'b1); end
    checks++;
    if (pending_count !== 6'd1) begin errors++; $display("FAIL sim_count: got %0d expected %0d", pending_count, 1); end
    wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 32'h77;
    tick();
    idle();
  endtask

  task automatic test_flush_reset;
    for (int i = 0; i < 3; i++) begin
      issue_valid = 1'b1; issue_addr = 5'(2 * (i + 1));
      tick();
    end
    issue_valid = 1'b0;
    #1;
    checks++;
    if (pending_count !== 6'd3) begin errors++; $display("FAIL flush_count3: got %0d expected %0d", pending_count, 3); end
    flush = 1'b1; issue_valid = 1'b1; issue_addr = 5'd9;
    tick();
    idle(); rd_addr_a = 5'd4; rd_addr_b = 5'd9;
    #1;
    checks++;
    if (pending_count !== 6'd0) begin errors++; $display("FAIL flush_count0: got %0d expected %0d", pending_count, 0); end
    checks++;
    if ({rd_busy_a, rd_busy_b} !== 2'b00) begin errors++; $display("FAIL flush_busy: got %b expected %b", {rd_busy_a, rd_busy_b}, 2'b00); end
    wb_valid = 1'b1; wb_addr = 5'd4; wb_data = 32'hAA; issue_valid = 1'b1; issue_addr = 5'd6;
    tick();
    idle();
    #1;
    checks++;
    if (rd_data_a !== 32'hAA || pending_count !== 6'd1) begin errors++; $display("FAIL pre_reset: got %h count %0d expected 000000aa count 1", rd_data_a, pending_count); end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (rd_data_a !== 32'h0) begin errors++; $display("FAIL async_reset_data: got %h expected %h", rd_data_a, 32'h0); end
    checks++;
    if (pending_count !== 6'd0) begin errors++; $display("FAIL async_reset_count: got %0d expected %0d", pending_count, 0); end
    reset = 1'b1;
    wb_valid = 1'b1; wb_addr = 5'd4; wb_data = 32'hC0FFEE01; issue_valid = 1'b1; issue_addr = 5'd10;
    tick();
    idle(); rd_addr_b = 5'd10;
    #1;
    checks++;
    if (rd_data_a !== 32'hC0FFEE01 || rd_busy_b !== 1'b1 || pending_count !== 6'd1) begin
      errors++; $display("FAIL post_reset: got %h busy %b count %0d expected c0ffee01 busy 1 count 1", rd_data_a, rd_busy_b, pending_count);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_zero_reg();
    test_scoreboard();
    test_simultaneous();
    test_flush_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
